// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared widths, core FIFO depth and tag type for the sqrt arbiter slice
package sqrt_pkg;
  localparam int SQRT_IN_W       = 32;
  localparam int SQRT_OUT_W      = 16;
  localparam int SQRT_FIFO_DEPTH = 16;
  localparam int SQRT_TAG_W      = 3;
  typedef logic [SQRT_TAG_W-1:0] sqrt_tag_t;
endpackage

// File: rtl/sqrt_arb_if.sv
// sqrt_arb_if: requester, core and response signals of the sqrt arbiter
interface sqrt_arb_if import sqrt_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
);
  logic [NUM_REQ-1:0]           req_vld;
  logic [SQRT_IN_W*NUM_REQ-1:0] req_x;
  logic [NUM_REQ-1:0]           req_rdy;
  logic                         hold;
  logic                         sq_vld_in;
  logic [SQRT_IN_W-1:0]         sq_x;
  logic                         sq_vld_out;
  logic [SQRT_OUT_W-1:0]        sq_y;
  logic                         rsp_vld;
  logic [IDW-1:0]               rsp_id;
  logic [SQRT_OUT_W-1:0]        rsp_y;
  logic                         idle;
  logic                         err;
  modport slave (
    input  req_vld, req_x, hold, sq_vld_out, sq_y,
    output req_rdy, sq_vld_in, sq_x, rsp_vld, rsp_id, rsp_y, idle, err
  );
  modport master (
    output req_vld, req_x, hold, sq_vld_out, sq_y,
    input  req_rdy, sq_vld_in, sq_x, rsp_vld, rsp_id, rsp_y, idle, err
  );
endinterface

// File: rtl/fifo.sv
// fifo: synchronous in-order FIFO of arbitrary depth with count-based full/empty
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full  = cnt_q == CW'(DEPTH);
  assign dout  = mem_q[rd_q];
  assign do_push = push & !full;
  assign do_pop  = pop & !empty;
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d  = do_push ? (wr_q == AW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d  = do_pop ? (rd_q == AW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/rr_arb.sv
// rr_arb: rotating-priority one-hot grant, searching upward from ptr modulo N
module rr_arb #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   vld,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx
);
  logic [IDW:0] j;
  always_comb begin
    idx = ptr;
    j   = '0;
    // scan farthest-first so the nearest requester at or after ptr wins
    for (int k = N - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + (IDW + 1)'(k);
      j = j >= (IDW + 1)'(N) ? j - (IDW + 1)'(N) : j;
      if (vld[j[IDW-1:0]]) idx = j[IDW-1:0];
    end
    gnt = (en && |vld) ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/sqrt_arb.sv
// sqrt_arb: round-robin sharing of one sqrt core with credit limit and in-order id tags
module sqrt_arb import sqrt_pkg::*; #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int IDW          = $clog2(NUM_REQ)
) (
  input logic        clk,
  input logic        rst_n,
  sqrt_arb_if.slave  bus
);
  if (MAX_INFLIGHT < 1 || MAX_INFLIGHT > SQRT_FIFO_DEPTH) begin : g_bad_inflight
    $error("MAX_INFLIGHT must lie in 1..SQRT_FIFO_DEPTH");
  end
  logic [NUM_REQ-1:0]    gnt;
  logic [IDW-1:0]        gnt_idx, tag, ptr_q, ptr_d, rsp_id_q, rsp_id_d;
  logic [4:0]            inflight_q, inflight_d;
  logic [SQRT_IN_W-1:0]  sq_x_q, sq_x_d;
  logic [SQRT_OUT_W-1:0] rsp_y_q, rsp_y_d;
  logic sq_vld_in_q, sq_vld_in_d, rsp_vld_q, rsp_vld_d, idle_q, idle_d, err_q, err_d;
  logic xfer, pop, empty, full, credit_ok;
  assign credit_ok = inflight_q < 5'(MAX_INFLIGHT);
  rr_arb #(.N(NUM_REQ), .IDW(IDW)) u_arb (
    .vld(bus.req_vld), .ptr(ptr_q), .en(rst_n & !bus.hold & credit_ok),
    .gnt(gnt), .idx(gnt_idx)
  );
  assign xfer = |gnt;
  assign pop  = bus.sq_vld_out & !empty;
  fifo #(.DATA_WIDTH(IDW), .DEPTH(MAX_INFLIGHT)) u_tags (
    .clk(clk), .rst_n(rst_n), .push(xfer), .din(gnt_idx), .pop(pop),
    .dout(tag), .empty(empty), .full(full)
  );
  assign bus.req_rdy   = gnt;
  assign bus.sq_vld_in = sq_vld_in_q;
  assign bus.sq_x      = sq_x_q;
  assign bus.rsp_vld   = rsp_vld_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.idle      = idle_q;
  assign bus.err       = err_q;
  always_comb begin
    ptr_d       = xfer ? (gnt_idx == IDW'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1) : ptr_q;
    inflight_d  = inflight_q + 5'(xfer) - 5'(pop);
    sq_vld_in_d = xfer;
    sq_x_d      = xfer ? bus.req_x[SQRT_IN_W*gnt_idx +: SQRT_IN_W] : sq_x_q;
    rsp_vld_d   = pop;
    rsp_id_d    = pop ? tag : rsp_id_q;
    rsp_y_d     = pop ? bus.sq_y : rsp_y_q;
    idle_d      = inflight_d == '0 && !xfer && !full;
    err_d       = err_q | (bus.sq_vld_out & empty);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      inflight_q  <= '0;
      sq_vld_in_q <= 1'b0;
      sq_x_q      <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      idle_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      inflight_q  <= inflight_d;
      sq_vld_in_q <= sq_vld_in_d;
      sq_x_q      <= sq_x_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      idle_q      <= idle_d;
      err_q       <= err_d;
    end
  end
endmodule
